// File: rtl/asm_endereco_atual.sv
// Playback-address controller: 22-bit sample address with play/pause, +/-10 s and +/-30 s seeks.
// Optional build macro ASM_ENDERECO_ATUAL_WRAP_EN: address wraps to 0 past the end instead of saturating.
module asm_endereco_atual (
    input  logic        clk,
    input  logic        reset,
    input  logic        passa_10s,
    input  logic        volta_10s,
    input  logic        passa_30s,
    input  logic        volta_30s,
    input  logic        count,
    output logic [21:0] endereco,
    output logic [5:0]  time_adder
);

    localparam logic [21:0] ADDR_MAX  = 22'h3FFFFF;
    localparam logic [21:0] DELTA_10S = 22'd655360;
    localparam logic [21:0] DELTA_30S = 22'd1966080;

    localparam logic [1:0] PAUSED  = 2'd0;
    localparam logic [1:0] PLAYING = 2'd1;
    localparam logic [1:0] AT_END  = 2'd2;

    logic [21:0] addr_q;
    logic [21:0] addr_d;
    logic [1:0]  state;

    // Button order matches seek priority: bit 3 wins.
    logic [3:0] btn;
    logic [3:0] btn_prev;
    logic [3:0] press;

    logic [22:0] sum_10;
    logic [22:0] sum_30;
    logic        fwd_10_ok;
    logic        fwd_30_ok;
    logic        back_10_ok;
    logic        back_30_ok;

    assign btn   = {passa_30s, volta_30s, passa_10s, volta_10s};
    assign press = btn & ~btn_prev;

    // State is a pure function of the play enable and where the address sits.
    always_comb begin
        state = PLAYING;
        if (!count) begin
            state = PAUSED;
        end
`ifndef ASM_ENDERECO_ATUAL_WRAP_EN
        else if (addr_q == ADDR_MAX) begin
            state = AT_END;
        end
`endif
    end

    // Forward bounds are evaluated one bit wider so they can never wrap.
    assign sum_10     = {1'b0, addr_q} + {1'b0, DELTA_10S};
    assign sum_30     = {1'b0, addr_q} + {1'b0, DELTA_30S};
    assign fwd_10_ok  = (sum_10 <= {1'b0, ADDR_MAX});
    assign fwd_30_ok  = (sum_30 <= {1'b0, ADDR_MAX});
    assign back_10_ok = (addr_q >= DELTA_10S);
    assign back_30_ok = (addr_q >= DELTA_30S);

    // A press cycle owns the address: out-of-range seeks leave it untouched, no increment.
    always_comb begin
        addr_d = addr_q;
        if (press[3]) begin
            if (fwd_30_ok) addr_d = sum_30[21:0];
        end else if (press[2]) begin
            if (back_30_ok) addr_d = addr_q - DELTA_30S;
        end else if (press[1]) begin
            if (fwd_10_ok) addr_d = sum_10[21:0];
        end else if (press[0]) begin
            if (back_10_ok) addr_d = addr_q - DELTA_10S;
        end else if (state == PLAYING) begin
            addr_d = addr_q + 22'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            btn_prev <= '0;
        end else begin
            addr_q   <= addr_d;
            btn_prev <= btn;
        end
    end

    assign endereco   = addr_q;
    assign time_adder = addr_q[21:16];

endmodule

// File: tb/tb_asm_endereco_atual.sv
// Scoreboard bench for asm_endereco_atual: directed stimulus pushes expected address/second pairs,
// a negedge monitor pops and compares.
module tb_asm_endereco_atual;

    logic        clk = 1'b0;
    logic        reset;
    logic        passa_10s, volta_10s, passa_30s, volta_30s, count;
    logic [21:0] endereco;
    logic [5:0]  time_adder;

    typedef struct {
        string       name;
        logic [21:0] addr;
        logic [5:0]  sec;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    asm_endereco_atual dut (
        .clk        (clk),
        .reset      (reset),
        .passa_10s  (passa_10s),
        .volta_10s  (volta_10s),
        .passa_30s  (passa_30s),
        .volta_30s  (volta_30s),
        .count      (count),
        .endereco   (endereco),
        .time_adder (time_adder)
    );

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_total++;
            if (endereco === e.addr && time_adder === e.sec) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got endereco=%0d time_adder=%0d, want endereco=%0d time_adder=%0d",
                         e.name, endereco, time_adder, e.addr, e.sec);
            end
        end
    end

    task automatic expect_now(input string name, input logic [21:0] a, input logic [5:0] s);
        exp_t e;
        e.name = name;
        e.addr = a;
        e.sec  = s;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        passa_10s = 0; volta_10s = 0; passa_30s = 0; volta_30s = 0; count = 0;
        #2 expect_now("reset_state", 22'd0, 6'd0);
        step(1);
        reset = 1'b1;
        count = 1'b1;
        step(100);
        expect_now("play_100", 22'd100, 6'd0);

        // Held +10 s: one jump only, then increments continue.
        passa_10s = 1'b1;
        step(1);
        expect_now("fwd10_jump", 22'd655460, 6'd10);
        step(9);
        expect_now("fwd10_held", 22'd655469, 6'd10);
        passa_10s = 1'b0;
        step(1);
        volta_10s = 1'b1;
        step(1);
        expect_now("back10", 22'd110, 6'd0);
        volta_10s = 1'b0;

        count = 1'b0;
        step(50);
        expect_now("pause_hold", 22'd110, 6'd0);
        count = 1'b1;
        step(1);
        expect_now("resume", 22'd111, 6'd0);
        step(389);
        count = 1'b0;
        expect_now("at_500", 22'd500, 6'd0);

        // Backward seeks below the delta are rejected.
        volta_10s = 1'b1;
        step(1);
        expect_now("back10_reject", 22'd500, 6'd0);
        volta_10s = 1'b0;
        volta_30s = 1'b1;
        step(1);
        expect_now("back30_reject", 22'd500, 6'd0);
        volta_30s = 1'b0;
        step(1);

        reset = 1'b0;
        #1 expect_now("async_reset_paused", 22'd0, 6'd0);
        step(1);
        reset = 1'b1;
        passa_30s = 1'b1;
        step(1);
        expect_now("fwd30_from0", 22'd1966080, 6'd30);
        passa_30s = 1'b0;
        step(1);
        passa_30s = 1'b1;
        step(1);
        expect_now("fwd30_to_3C0000", 22'h3C0000, 6'd60);
        passa_30s = 1'b0;
        step(1);
        passa_30s = 1'b1;
        step(1);
        expect_now("fwd30_reject", 22'h3C0000, 6'd60);
        passa_30s = 1'b0;
        step(1);

        // Simultaneous presses: highest priority wins, the others are consumed.
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        passa_30s = 1'b1;
        volta_10s = 1'b1;
        step(1);
        expect_now("prio_p30_v10", 22'd1966080, 6'd30);
        passa_30s = 1'b0;
        volta_10s = 1'b0;
        step(1);
        expect_now("prio_consumed", 22'd1966080, 6'd30);
        volta_30s = 1'b1;
        passa_10s = 1'b1;
        step(1);
        expect_now("prio_v30_p10", 22'd0, 6'd0);
        volta_30s = 1'b0;
        passa_10s = 1'b0;
        step(1);

        // Button held across reset release counts as a press.
        reset = 1'b0;
        passa_10s = 1'b1;
        step(2);
        reset = 1'b1;
        step(1);
        expect_now("press_across_reset", 22'd655360, 6'd10);
        passa_10s = 1'b0;
        step(1);

        // End of memory: preload near the top, then play.
        force dut.addr_q = 22'h3FFFFD;
        #1 release dut.addr_q;
        count = 1'b1;
        step(2);
        expect_now("reach_end", 22'h3FFFFF, 6'd63);
        step(1);
`ifdef ASM_ENDERECO_ATUAL_WRAP_EN
        expect_now("end_wrap", 22'd0, 6'd0);
        step(2);
        expect_now("after_wrap", 22'd2, 6'd0);
`else
        expect_now("end_hold", 22'h3FFFFF, 6'd63);
        step(2);
        expect_now("end_hold_more", 22'h3FFFFF, 6'd63);
        volta_10s = 1'b1;
        step(1);
        expect_now("leave_end_back10", 22'h35FFFF, 6'd53);
        volta_10s = 1'b0;
        step(1);
        expect_now("play_after_end", 22'h360000, 6'd54);
`endif
        step(3);
        reset = 1'b0;
        #1 expect_now("async_reset_playing", 22'd0, 6'd0);

        begin
            int guard;
            guard = 0;
            while (sb.size() > 0 && guard < 20) begin
                @(posedge clk);
                guard++;
            end
            if (sb.size() > 0) begin
                n_total++;
                $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/asm_endereco_atual.md
# asm_endereco_atual

Playback-address controller for the music player. It generates the 22-bit sample address `endereco` that drives the audio memory. The address advances one sample per enabled clock, and four seek buttons jump it ±10 s or ±30 s. It also reports the current playback second on `time_adder` for the display/timer path.

## Interface
- No parameters. The rate is fixed at 65536 samples per second (2^16). One second equals 65536 address steps.
- `clk` input 1: system clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. When it is 0, all state clears immediately.
- `passa_10s` input 1: +10 s seek button, level signal, held high for any number of cycles.
- `volta_10s` input 1: −10 s seek button.
- `passa_30s` input 1: +30 s seek button.
- `volta_30s` input 1: −30 s seek button.
- `count` input 1: play enable. 1 means playing, 0 means paused.
- `endereco` output 22: current sample address, registered.
- `time_adder` output 6: current playback second, always equal to `endereco[21:16]` (0–63).

## Operation
- FSM states:
  - PAUSED: `count`=0.
  - PLAYING: `count`=1 and address < 22'h3FFFFF.
  - AT_END: `count`=1 and address = 22'h3FFFFF.
- The state is re-evaluated every clock from `count` and the address.
- Edge detection:
  - Each button has a previous-sample register, reset to 0.
  - A press is the cycle where the button is 1 and its previous sample is 0.
  - A held button produces exactly one seek.
- Seek deltas: ±10 s = ±655360, ±30 s = ±1966080.
- Seek rules:
  - Forward seek applies only if address + delta ≤ 22'h3FFFFF. Otherwise the address is unchanged and there is no clamp.
  - Backward seek applies only if address ≥ delta. Otherwise the address is unchanged and there is no clamp to 0.
  - Seeks work in every state, including PAUSED.
- Simultaneous presses in one cycle: only one is honoured. Priority is `passa_30s` > `volta_30s` > `passa_10s` > `volta_10s`. The others are discarded, since their edges are consumed.
- Increment: in PLAYING, when no seek is applied that cycle, `endereco` ← `endereco`+1.
- A seek cycle replaces the increment. There is no +1 on top of a seek.
- PAUSED: the address holds apart from seeks.
- `time_adder` is purely combinational from `endereco[21:16]`. It has no separate counter and cannot disagree with the address.

## Timing
- Reset values: `endereco`=0, `time_adder`=0, edge registers=0, state PAUSED.
- Reset is asynchronous. Asserting `reset`=0 mid-play clears the outputs without waiting for a clock.
- After release, operation resumes on the next rising edge.
- A button held high across reset release counts as a press on the first edge after release.
- Seek latency: the new address appears after the first rising edge at which the button samples 1 with previous sample 0. That is one clock.
- Increment latency: `count` sampled 1 at edge n gives `endereco`+1 after edge n.
- There is no pipelining. Seek and increment are never both visible in one cycle.

## Configuration
- Macro: `ASM_ENDERECO_ATUAL_WRAP_EN`.
- Defined:
  - In PLAYING at 22'h3FFFFF, the next increment wraps to 0 and `time_adder` returns to 0.
  - The AT_END state does not exist.
- Undefined:
  - The address saturates at 22'h3FFFFF in AT_END while `count`=1.
  - Only a backward seek or reset leaves AT_END.
- Seek bound checks are identical in both builds. Forward seeks never wrap.

## Test plan
- Reset then play: `reset`=0→1, `count`=1 for 100 clocks → `endereco`=100, `time_adder`=0.
- +10 s press held 10 cycles at address 100 → exactly one jump to 655460 (plus subsequent increments), `time_adder`=10. Then −10 s → back to the running address minus 655360, `time_adder`=0.
- Pause: `count`=0 for 50 clocks → `endereco` constant. `count`=1 again → increments resume the next clock.
- Bound checks:
  - −10 s and −30 s at `endereco`=500 → unchanged.
  - +30 s at 0 → 1966080, `time_adder`=30.
  - +30 s at 0x3C0000 → unchanged.
- Simultaneous `passa_30s` and `volta_10s` rising in the same cycle at address 0 → 1966080 only.
- End of memory: address 22'h3FFFFF with `count`=1 → holds (no macro) or wraps to 0 (with `ASM_ENDERECO_ATUAL_WRAP_EN`). Asynchronous `reset`=0 between clock edges → `endereco`=0 immediately.
